plic_lite: RTL

Platform-level interrupt controller that sits directly upstream of the core's `irq_ext` input and is mapped as a D-bus slave beside the CLINT. It collects level-triggered external sources (GPIO, peripherals) and gates each through a pending/in-flight gateway. It arbitrates the enabled pending sources by priority against a threshold, drives a registered `irq_ext`, and implements the claim/complete protocol (RISC-V PLIC subset, single hart, M-mode context only). A thin wrapper adapts the flat bus ports below to `slave_bus_if` and inverts `rst_n`.

---
 rtl/plic_lite.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/plic_lite.sv
// plic_lite: single-hart, M-mode-only PLIC subset. Level sources pass a
// 2-flop synchronizer and a pending/in-flight gateway. A combinational
// priority arbiter feeds a registered irq_ext, and claim/complete run
// over a flat single-cycle request / next-cycle ack bus.
module plic_lite #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   src,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [21:0]       bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic              irq_ext
);

  // Word addresses (byte offset >> 2) of the fixed registers
  localparam logic [19:0] WA_PEND  = 20'h00400;
  localparam logic [19:0] WA_EN    = 20'h00800;
  localparam logic [19:0] WA_THR   = 20'h80000;
  localparam logic [19:0] WA_CLAIM = 20'h80001;

  // Vector bit i holds the state of source ID i+1
  logic [NSRC-1:0]   meta_q, sync_q;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [NSRC-1:0]   infl_q, infl_d;
  logic [NSRC-1:0]   en_q, en_d;
  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [PRIO_W-1:0] prio_d [NSRC];
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic              irq_q, irq_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [19:0]       waddr;
  logic              in_prio_win;
  logic              rd_acc, wr_acc;
  logic              claim_fire, cmpl_acc;
  logic [4:0]        cmpl_id;
  logic [4:0]        max_id;
  logic [PRIO_W-1:0] max_prio;
  logic [31:0]       rd_word;
  logic              unused_bits;

  assign waddr       = bus_addr[21:2];
  assign in_prio_win = (waddr[19:10] == 10'd0);
  assign rd_acc      = bus_req & ~bus_we;
  assign wr_acc      = bus_req & bus_we;
  // A claim only has side effects when there is something to hand out
  assign claim_fire  = rd_acc && (waddr == WA_CLAIM) && (max_id != 5'd0);
  assign cmpl_acc    = wr_acc && (waddr == WA_CLAIM);
  assign cmpl_id     = bus_wdata[4:0];
  // Byte-lane bits and high write-data bits carry no meaning here
  assign unused_bits = ^{bus_wdata, bus_addr[1:0]};

  // Arbiter: ascending scan with strict compare keeps the lowest ID on ties
  always_comb begin
    max_id   = 5'd0;
    max_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pend_q[i] && en_q[i] && (prio_q[i] > max_prio)) begin
        max_prio = prio_q[i];
        max_id   = 5'(i + 1);
      end
    end
  end

  // Read mux: unmapped words and ID 0 priority read as zero
  always_comb begin
    rd_word = '0;
    if (in_prio_win) begin
      for (int i = 0; i < NSRC; i++) begin
        if (waddr[9:0] == 10'(i + 1)) rd_word[PRIO_W-1:0] = prio_q[i];
      end
    end else if (waddr == WA_PEND) begin
      rd_word[NSRC:1] = pend_q;
    end else if (waddr == WA_EN) begin
      rd_word[NSRC:1] = en_q;
    end else if (waddr == WA_THR) begin
      rd_word[PRIO_W-1:0] = thr_q;
    end else if (waddr == WA_CLAIM) begin
      rd_word[4:0] = max_id;
    end
  end

  // Next state: register writes, gateway updates, irq and bus response
  always_comb begin
    en_d   = en_q;
    thr_d  = thr_q;
    prio_d = prio_q;
    pend_d = pend_q;
    infl_d = infl_q;
    if (wr_acc) begin
      if (in_prio_win) begin
        for (int i = 0; i < NSRC; i++) begin
          if (waddr[9:0] == 10'(i + 1)) prio_d[i] = bus_wdata[PRIO_W-1:0];
        end
      end
      if (waddr == WA_EN)  en_d  = bus_wdata[NSRC:1];
      if (waddr == WA_THR) thr_d = bus_wdata[PRIO_W-1:0];
    end
    for (int i = 0; i < NSRC; i++) begin
      // Claim beats a same-edge rising source; a completed source re-arms
      // one edge later because the set term looks at the registered inflight
      if (claim_fire && (max_id == 5'(i + 1))) begin
        pend_d[i] = 1'b0;
        infl_d[i] = 1'b1;
      end else if (sync_q[i] && !pend_q[i] && !infl_q[i]) begin
        pend_d[i] = 1'b1;
      end
      if (cmpl_acc && (cmpl_id == 5'(i + 1)) && en_q[i] && infl_q[i]) begin
        infl_d[i] = 1'b0;
      end
    end
    irq_d   = (max_id != 5'd0) && (max_prio > thr_q);
    ack_d   = bus_req;
    rdata_d = rd_acc ? rd_word : 32'd0;
  end

  // State registers; reset also aborts any access awaiting its ack
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      pend_q  <= '0;
      infl_q  <= '0;
      en_q    <= '0;
      thr_q   <= '0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < NSRC; i++) prio_q[i] <= '0;
    end else begin
      meta_q  <= src;
      sync_q  <= meta_q;
      pend_q  <= pend_d;
      infl_q  <= infl_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      prio_q  <= prio_d;
    end
  end

  assign irq_ext   = irq_q;
  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;

endmodule
